pc_fetch: RTL and testbench

Program-counter and instruction-fetch stage of the MIPS CPU. Holds the PC and issues fetch requests to instruction memory with a ready handshake. Presents each fetched word to decode and, when decode accepts it, selects the next PC. The branch target is built from the 32-bit extended immediate produced by the immediate extender, which sits directly upstream of this block's branch adder.

---
 rtl/pc_fetch_if.sv | 38 +++
 rtl/pc_fetch.sv | 136 +++++++++++++
 tb/tb_pc_fetch.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_if
// Brief    : Instruction-memory request bus and decode hand-off handshake.
// Revision : 1.0
// ============================================================================
interface pc_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_accept;

    // Fetch stage side: drives the memory request and presents words to decode.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata,
        output instr,
        output instr_valid,
        input  instr_accept
    );

    // Memory and decode side.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata,
        input  instr,
        input  instr_valid,
        output instr_accept
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch
// Brief    : MIPS program counter and instruction-fetch stage with ready
//            handshake towards memory and valid/accept towards decode.
// Revision : 1.0
// ============================================================================
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    pc_fetch_if.master       bus,
    input  wire logic [31:0] ext_imm,
    input  wire logic [25:0] jtarget,
    input  wire logic        branch,
    input  wire logic        zero,
    input  wire logic        jump,
    input  wire logic        jr,
    input  wire logic [31:0] jr_addr,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             addr_err
);

    localparam logic [31:0] c_pc_step = 32'd4;

    generate
        if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_misaligned
            $error("pc_fetch: RESET_PC must be word-aligned");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      state_q,       state_d;
    logic [31:0] pc_q,          pc_d;
    logic [31:0] instr_q,       instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        imem_req_q,    imem_req_d;
    logic        addr_err_q,    addr_err_d;

    logic [31:0] seq_pc;
    logic [31:0] branch_off;
    logic [31:0] next_pc;
    logic        jr_misaligned;

    assign seq_pc        = pc_q + c_pc_step;
    // Shifting the whole word drops ext_imm[31:30] as modulo arithmetic requires.
    assign branch_off    = ext_imm << 2;
    assign jr_misaligned = jr && (jr_addr[1:0] != 2'b00);

    always_comb begin
        next_pc = seq_pc;
        if (jr) begin
            next_pc = {jr_addr[31:2], 2'b00};
        end else if (jump) begin
            next_pc = {seq_pc[31:28], jtarget, 2'b00};
        end else if (branch && zero) begin
            next_pc = seq_pc + branch_off;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        imem_req_d    = imem_req_q;
        addr_err_d    = addr_err_q;

        unique case (state_q)
            ST_IDLE: begin
                state_d    = ST_FETCH;
                imem_req_d = 1'b1;
            end
            ST_FETCH: begin
                if (bus.imem_ready) begin
                    instr_d       = bus.imem_rdata;
                    instr_valid_d = 1'b1;
                    imem_req_d    = 1'b0;
                    state_d       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // A coincident imem_ready here is a stale response and is ignored.
                if (bus.instr_accept) begin
                    pc_d          = next_pc;
                    instr_valid_d = 1'b0;
                    imem_req_d    = 1'b1;
                    state_d       = ST_FETCH;
                    if (jr_misaligned) begin
                        addr_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d       = ST_IDLE;
                instr_valid_d = 1'b0;
                imem_req_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'd0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
            addr_err_q    <= addr_err_d;
        end
    end

    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign pc              = pc_q;
    assign pc_plus4        = seq_pc;
    assign addr_err        = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch
// Brief    : Directed and randomized bench for pc_fetch against a cycle model.
// Revision : 1.0
// ============================================================================
module tb_pc_fetch;

    localparam logic [31:0] c_reset_pc = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ext_imm;
    logic [25:0] jtarget;
    logic        branch, zero, jump, jr;
    logic [31:0] jr_addr;
    logic [31:0] pc, pc_plus4;
    logic        addr_err;

    pc_fetch_if bus();

    pc_fetch #(.RESET_PC(c_reset_pc)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ext_imm  (ext_imm),
        .jtarget  (jtarget),
        .branch   (branch),
        .zero     (zero),
        .jump     (jump),
        .jr       (jr),
        .jr_addr  (jr_addr),
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state, described by what is observable at the ports.
    logic [31:0] m_pc, m_instr;
    logic        m_req, m_valid, m_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_next_pc(input logic [31:0] cur);
        logic [31:0] seq;
        seq = cur + 32'd4;
        if (jr)            return jr_addr & 32'hFFFF_FFFC;
        if (jump)          return (seq & 32'hF000_0000) | ({6'd0, jtarget} * 32'd4);
        if (branch && zero) return seq + ext_imm * 32'd4;
        return seq;
    endfunction

    task automatic model_reset();
        m_pc = c_reset_pc; m_instr = 32'd0; m_req = 1'b0; m_valid = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_edge();
        if (m_valid) begin
            if (bus.instr_accept) begin
                if (jr && (jr_addr % 4) != 0) m_err = 1'b1;
                m_pc    = ref_next_pc(m_pc);
                m_valid = 1'b0;
                m_req   = 1'b1;
            end
        end else if (m_req) begin
            if (bus.imem_ready) begin
                m_instr = bus.imem_rdata;
                m_valid = 1'b1;
                m_req   = 1'b0;
            end
        end else begin
            m_req = 1'b1;
        end
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, ".pc"},       pc,              m_pc);
        check_eq({tag, ".pc_plus4"}, pc_plus4,        m_pc + 32'd4);
        check_eq({tag, ".addr"},     bus.imem_addr,   m_pc);
        check_eq({tag, ".req"},      bus.imem_req,    m_req);
        check_eq({tag, ".valid"},    bus.instr_valid, m_valid);
        check_eq({tag, ".instr"},    bus.instr,       m_instr);
        check_eq({tag, ".err"},      addr_err,        m_err);
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic set_ctrl(input logic b, input logic z, input logic j, input logic r,
                            input logic [31:0] ja, input logic [25:0] jt, input logic [31:0] imm);
        branch = b; zero = z; jump = j; jr = r; jr_addr = ja; jtarget = jt; ext_imm = imm;
    endtask

    // One full fetch + same-cycle accept with the given controls.
    task automatic do_instr(input string tag, input logic b, input logic z, input logic j,
                            input logic r, input logic [31:0] ja, input logic [25:0] jt,
                            input logic [31:0] imm);
        set_ctrl(b, z, j, r, ja, jt, imm);
        bus.imem_ready = 1'b1; bus.imem_rdata = $urandom; bus.instr_accept = 1'b0;
        step({tag, ".f"});
        bus.imem_ready = 1'b0; bus.instr_accept = 1'b1;
        step({tag, ".a"});
        bus.instr_accept = 1'b0;
        set_ctrl(0, 0, 0, 0, 32'd0, 26'd0, 32'd0);
    endtask

    task automatic random_run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bus.imem_ready   = 1'($urandom_range(0, 1));
            bus.instr_accept = 1'($urandom_range(0, 1));
            bus.imem_rdata   = $urandom;
            branch  = 1'($urandom_range(0, 1));
            zero    = 1'($urandom_range(0, 1));
            jump    = 1'($urandom_range(0, 3) == 0);
            jr      = 1'($urandom_range(0, 3) == 0);
            jr_addr = $urandom;
            if ($urandom_range(0, 7) != 0) jr_addr = jr_addr & 32'hFFFF_FFFC;
            jtarget = 26'($urandom);
            ext_imm = $urandom;
            step("rand");
        end
        bus.imem_ready = 1'b0; bus.instr_accept = 1'b0;
        set_ctrl(0, 0, 0, 0, 32'd0, 26'd0, 32'd0);
    endtask

    logic [31:0] pc_saved;

    initial begin
        bus.imem_ready = 1'b0; bus.imem_rdata = 32'd0; bus.instr_accept = 1'b0;
        set_ctrl(0, 0, 0, 0, 32'd0, 26'd0, 32'd0);
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        compare_all("reset");
        check_eq("reset.pc_const", pc, 32'h0000_3000);
        rst_n = 1'b1;
        step("startup");
        check_eq("startup.req_const",  bus.imem_req,  32'd1);
        check_eq("startup.addr_const", bus.imem_addr, 32'h0000_3000);

        bus.imem_ready = 1'b1; bus.imem_rdata = 32'h2008_0005;
        step("seq.fetch");
        check_eq("seq.instr_const", bus.instr, 32'h2008_0005);
        check_eq("seq.valid_const", bus.instr_valid, 32'd1);
        bus.imem_ready = 1'b0; bus.instr_accept = 1'b1;
        step("seq.accept");
        bus.instr_accept = 1'b0;
        check_eq("seq.pc_const", pc, 32'h0000_3004);
        check_eq("seq.valid_drop", bus.instr_valid, 32'd0);

        do_instr("br_taken", 1, 1, 0, 0, 32'd0, 26'd0, 32'hFFFF_FFFE);
        check_eq("br_taken.pc_const", pc, 32'h0000_3000);
        do_instr("seq2", 0, 0, 0, 0, 32'd0, 26'd0, 32'd0);
        do_instr("br_not", 1, 0, 0, 0, 32'd0, 26'd0, 32'hFFFF_FFFE);
        check_eq("br_not.pc_const", pc, 32'h0000_3008);

        do_instr("goto1", 0, 0, 0, 1, 32'h0000_3004, 26'd0, 32'd0);
        do_instr("prio1", 0, 0, 1, 1, 32'h0000_3100, 26'h0000C40, 32'd0);
        check_eq("prio1.pc_const", pc, 32'h0000_3100);
        do_instr("goto2", 0, 0, 0, 1, 32'h0000_3004, 26'd0, 32'd0);
        do_instr("prio2", 0, 0, 1, 1, 32'h0000_3200, 26'h0000C40, 32'd0);
        check_eq("prio2.pc_const", pc, 32'h0000_3200);
        do_instr("goto3", 0, 0, 0, 1, 32'h0000_3004, 26'd0, 32'd0);
        do_instr("jonly", 1, 1, 1, 0, 32'd0, 26'h0000C40, 32'h0000_0100);
        check_eq("jonly.pc_const", pc, 32'h0000_3100);
        do_instr("goto4", 0, 0, 0, 1, 32'h0000_3004, 26'd0, 32'd0);
        check_eq("goto4.err_clear", addr_err, 32'd0);
        do_instr("misal", 0, 0, 0, 1, 32'h0000_3102, 26'd0, 32'd0);
        check_eq("misal.pc_const", pc, 32'h0000_3100);
        check_eq("misal.err_const", addr_err, 32'd1);
        do_instr("sticky", 0, 0, 0, 0, 32'd0, 26'd0, 32'd0);
        check_eq("sticky.err_const", addr_err, 32'd1);

        pc_saved = pc;
        bus.imem_ready = 1'b0; bus.instr_accept = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("wait");
            check_eq("wait.req_const",   bus.imem_req,    32'd1);
            check_eq("wait.valid_const", bus.instr_valid, 32'd0);
            check_eq("wait.pc_stable",   pc,              pc_saved);
        end
        bus.instr_accept = 1'b0; bus.imem_ready = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        step("wait.cap");
        check_eq("wait.cap_instr", bus.instr, 32'hDEAD_BEEF);
        bus.instr_accept = 1'b1; bus.imem_rdata = 32'h1111_1111;
        step("coincide");
        check_eq("coincide.pc",    pc,        pc_saved + 32'd4);
        check_eq("coincide.instr", bus.instr, 32'hDEAD_BEEF);
        bus.instr_accept = 1'b0; bus.imem_ready = 1'b0;

        random_run(300);

        bus.imem_ready = 1'b1;
        for (int i = 0; i < 4 && !m_valid; i++) step("to_hold");
        bus.imem_ready = 1'b0;
        check_eq("pre_rst.valid", bus.instr_valid, 32'd1);
        check_eq("pre_rst.err",   addr_err,        32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("restart");

        random_run(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
